// File: rtl/my_mux8way_rr.sv
// Eight-channel round-robin merge into one registered valid/ready stream.
// Each output word is tagged with the index of the channel that supplied it.
module my_mux8way_rr #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [8*WIDTH-1:0] in_data,
    input  logic [7:0]         in_valid,
    output logic [7:0]         in_ready,
    output logic [WIDTH-1:0]   out,
    output logic [2:0]         out_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         o_dbg_ptr
);

    // Handshake: a word moves on an interface at any rising edge where its
    // valid and ready are both high; ready never waits on valid being held.
    logic [WIDTH-1:0] r_out;
    logic [2:0]       r_sel;
    logic             r_valid;
    logic [2:0]       r_ptr;

    logic             w_load;
    logic             w_found;
    logic [2:0]       w_win;

    // The holding register can refill whenever it is empty or draining now.
    assign w_load = !r_valid || out_ready;

    always_comb begin
        logic [2:0] w_cand;
        w_found = 1'b0;
        w_win   = 3'd0;
        w_cand  = r_ptr;
        for (int i = 0; i < 8; i++) begin
            w_cand = r_ptr + 3'(i);
            if (!w_found && in_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign in_ready = (w_found && w_load && !reset) ? (8'd1 << w_win) : 8'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out   <= '0;
            r_sel   <= 3'd0;
            r_valid <= 1'b0;
            r_ptr   <= 3'd0;
        end else if (w_load) begin
            if (w_found) begin
                r_out   <= in_data[w_win*WIDTH +: WIDTH];
                r_sel   <= w_win;
                r_valid <= 1'b1;
                r_ptr   <= w_win + 3'd1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out       = r_out;
    assign out_sel   = r_sel;
    assign out_valid = r_valid;
    assign o_dbg_ptr = r_ptr;

endmodule

// File: doc/my_mux8way_rr.md
# my_mux8way_rr

Registered 8-to-1 round-robin merge: collects words from eight valid/ready source channels into one output stream, tagging each word with the 3-bit index of the channel it came from. It is the gathering end of the 8-way demultiplex path. The `out_sel` tag has the same encoding as a dmux8way `sel`, so a downstream demux can route a word straight back to its lane. The block provides per-word flow control and fair arbitration, so no channel can starve another.

## Interface
- `WIDTH`, default 16: data width of every channel (machine word).
- `clk` input, 1 bit: sole clock; all state updates on its rising edge.
- `reset` input, 1 bit: synchronous, active-high; sampled on the rising edge of `clk`.
- `in_data` input, 8*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid` input, 8 bits: bit k set means channel k presents a word.
- `in_ready` output, 8 bits: bit k set means channel k's word is taken this cycle. Combinational; at most one bit set.
- `out` output, WIDTH bits: registered output word.
- `out_sel` output, 3 bits: index of the channel that supplied `out`.
- `out_valid` output, 1 bit: `out` and `out_sel` hold a word.
- `out_ready` input, 1 bit: downstream accepts the word this cycle.

## Operation
- State:
  - one output holding register (`out`, `out_sel`, `out_valid`);
  - 3-bit round-robin pointer `ptr`.
- A transfer happens on an interface in any cycle where its valid and ready are both high at the rising edge.
- Load enable: `load = !out_valid || out_ready`. The register can take a new word when it is empty or when it is draining this same cycle.
- Arbitration (combinational):
  - Search channels `ptr`, `ptr+1`, …, `ptr+7` (mod 8) in that order.
  - The winner `w` is the first channel with `in_valid` set.
  - If no channel is valid, there is no grant.
- `in_ready[w] = load` when a winner exists. All other `in_ready` bits are 0. All bits are 0 when there is no winner.
- On a cycle with a grant and `load`:
  - `out <= in_data[w]`;
  - `out_sel <= w`;
  - `out_valid <= 1`;
  - `ptr <= w+1` (mod 8; 7 wraps to 0).
- On a cycle with `load` and no grant:
  - `out_valid <= 0`;
  - `out` and `out_sel` hold their values;
  - `ptr` holds.
- On a cycle without `load` (`out_valid=1`, `out_ready=0`): all state holds and `in_ready` is all zero.
- The pointer advances only on an accepted input word, never on idle cycles.
- Simultaneous drain and fill (`out_valid=1`, `out_ready=1`, winner present): the old word leaves and the new word is loaded on the same edge, with no bubble.
- Sources must hold `in_valid` and `in_data` stable until their transfer completes. The block does not require this for correctness, but it is assumed by the test plan.

## Timing
- Reset values: `out`=0, `out_sel`=0, `out_valid`=0, `ptr`=0. While `reset` is high, `in_ready`=0.
- Reset mid-operation discards any word held in the register. No channel is acknowledged on the reset edge.
- Latency: an input accepted at edge N appears on `out` with `out_valid=1` immediately after edge N (one register stage).
- Throughput: one word per cycle while `out_ready` is held high and any channel is valid.
- Fairness: with all 8 channels continuously valid and `out_ready` high, grants cycle 0,1,…,7,0,…. Each channel is served at least once in any 8 consecutive accepted words.
- Combinational paths: `in_valid` and `out_ready` to `in_ready`. There is no combinational path from input to `out`, `out_sel` or `out_valid`.

## Test plan
- Reset: hold `reset` for 2 cycles with arbitrary inputs.
  - Required: `out_valid`=0, `out`=0, `out_sel`=0, `in_ready`=0.
  - After release with `in_valid=8'h08`, `in_data` lane 3 = 16'h00A3: one cycle later `out`=16'h00A3, `out_sel`=3.
- Full rotation: all `in_valid`=8'hFF, lane k data = 16'h1000+k, `out_ready`=1.
  - Required: `out_sel` sequence 0,1,2,…,7,0,1, with matching data, one word per cycle.
- Wrap and skip: `ptr`=6, `in_valid`=8'b0000_0101.
  - Required: grant to lane 0, then lane 2, then lane 0. `ptr` goes 1, 3, 1.
- Backpressure: lanes 1 and 5 valid; after the first word loads, hold `out_ready`=0 for 4 cycles.
  - Required: `out`/`out_sel` stay at lane 1's word and `in_ready`=0 throughout.
  - When `out_ready` rises: lane 5 loads on the same edge that lane 1's word drains.
- Idle drain: single word from lane 7, then `in_valid`=0, `out_ready`=1.
  - Required: `out_valid` is high for exactly one cycle, then 0.
  - `out_sel` holds 7, `ptr` holds 0.
- Reset mid-stream: during the full-rotation test, assert `reset` when `out_sel`=4.
  - Required: next cycle `out_valid`=0.
  - After release, the first grant is lane 0.
